// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and helpers for the systolic feed controller.
package systolic_pkg;

   localparam int N          = 4;
   localparam int DATA_W     = 16;
   localparam int BEAT_W     = 256;
   localparam int BEAT_BYTES = BEAT_W / 8;

   // FEED walks the skew diagonal: N columns plus 2*(N-1) cycles of stagger.
   function automatic int feed_len(input int n);
      return 3 * n - 2;
   endfunction

   // DRAIN keeps the array advancing until the last partial products settle.
   function automatic int drain_len(input int n);
      return n;
   endfunction

   localparam int FEED_LEN  = feed_len(N);
   localparam int DRAIN_LEN = drain_len(N);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_REQ_W  = 3'd2,
      S_WAIT_W = 3'd3,
      S_REQ_X  = 3'd4,
      S_WAIT_X = 3'd5,
      S_FEED   = 3'd6,
      S_DRAIN  = 3'd7
   } state_t;

endpackage

// File: rtl/systolic_skew_feeder.sv
// Holds one W and one X tile and replays them as skewed row/column feeds.
module systolic_skew_feeder #(
   parameter int N      = systolic_pkg::N,
   parameter int DATA_W = systolic_pkg::DATA_W,
   parameter int BEAT_W = systolic_pkg::BEAT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_w,
   input  logic                     load_x,
   input  logic [BEAT_W-1:0]        beat,
   input  logic [N-1:0]             k_valid,
   input  logic                     feed_active,
   output logic                     feed_last,
   output logic signed [DATA_W-1:0] a_left [N],
   output logic signed [DATA_W-1:0] b_top  [N]
);
   import systolic_pkg::*;

   localparam int F  = feed_len(N);
   localparam int TW = (F > 1) ? $clog2(F) : 1;

   logic [TW-1:0]            t_q;
   logic signed [DATA_W-1:0] w_buf [N][N];
   logic signed [DATA_W-1:0] x_buf [N][N];

   assign feed_last = feed_active && (t_q == TW'(F - 1));

   // Capture tiles; k positions beyond the reduction length are stored as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
               w_buf[r][k] <= '0;
               x_buf[k][r] <= '0;
            end
         end
      end else begin
         for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
               if (load_w) begin
                  w_buf[r][k] <= k_valid[k] ? beat[(r*N+k)*DATA_W +: DATA_W] : '0;
               end
               if (load_x) begin
                  x_buf[k][r] <= k_valid[k] ? beat[(k*N+r)*DATA_W +: DATA_W] : '0;
               end
            end
         end
      end
   end

   // Feed-cycle counter: runs only inside FEED and rewinds after the last cycle.
   always_ff @(posedge clk) begin
      if (reset || !feed_active || feed_last) begin
         t_q <= '0;
      end else begin
         t_q <= t_q + TW'(1);
      end
   end

   // Row i sees W[i][t-i], column j sees X[t-j][j]; everything else is zero.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_left[i] = '0;
         b_top[i]  = '0;
         for (int k = 0; k < N; k++) begin
            if (feed_active && (int'(t_q) == i + k)) begin
               a_left[i] = w_buf[i][k];
               b_top[i]  = x_buf[k][i];
            end
         end
      end
   end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Chunk sequencer: fetches W/X tiles over a single-outstanding DMA port and
// drives the systolic array's clear/enable plus skewed operand feeds.
//
// DMA request handshake: dma_re/dma_addr are held stable from the first cycle
// of a request until dma_req_ready is sampled high on a rising edge; that edge
// accepts the request. The data beat is taken only on a later edge where
// dma_resp_valid is high while waiting for it; beats at any other time are dropped.
module systolic_feed_ctrl #(
   parameter int N      = systolic_pkg::N,
   parameter int DATA_W = systolic_pkg::DATA_W
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [31:0]                          w_addr,
   input  logic [31:0]                          x_addr,
   input  logic [31:0]                          k_dim,
   input  logic [31:0]                          x_stride,
   output logic [31:0]                          dma_addr,
   output logic                                 dma_re,
   input  logic                                 dma_req_ready,
   input  logic                                 dma_resp_valid,
   input  logic [systolic_pkg::BEAT_W-1:0]      dma_rdata,
   output logic                                 clear_acc,
   output logic                                 en,
   output logic signed [DATA_W-1:0]             a_left [N],
   output logic signed [DATA_W-1:0]             b_top  [N],
   output logic                                 busy,
   output logic                                 done,
   output systolic_pkg::state_t                 dbg_state
);
   import systolic_pkg::*;

   localparam int DCW = (N > 1) ? $clog2(N) : 1;

   state_t         state_q, state_d;
   logic [31:0]    w_ptr_q, x_ptr_q, x_stride_q;
   // Elements still to be reduced from the current chunk onward; the chunk
   // loop continues while more than N remain, which equals c+1 < ceil(k/N).
   logic [31:0]    k_rem_q;
   logic [DCW-1:0] drain_cnt_q;
   logic           done_q;

   logic           load_w, load_x, feed_active, feed_last;
   logic [N-1:0]   k_valid;
   logic           more_chunks, drain_last;

   assign more_chunks = k_rem_q > 32'(N);
   assign drain_last  = drain_cnt_q == DCW'(N - 1);
   assign busy        = state_q != S_IDLE;
   assign done        = done_q;
   assign dbg_state   = state_q;

   // Per-k validity of the chunk being fetched (tail masking).
   always_comb begin
      for (int kk = 0; kk < N; kk++) begin
         k_valid[kk] = k_rem_q > 32'(kk);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore outputs; all outputs depend on state only.
   always_comb begin
      state_d     = state_q;
      dma_re      = 1'b0;
      dma_addr    = '0;
      clear_acc   = 1'b0;
      en          = 1'b0;
      load_w      = 1'b0;
      load_x      = 1'b0;
      feed_active = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            clear_acc = 1'b1;
            state_d   = (k_rem_q == '0) ? S_IDLE : S_REQ_W;
         end
         S_REQ_W: begin
            dma_re   = 1'b1;
            dma_addr = w_ptr_q;
            if (dma_req_ready) state_d = S_WAIT_W;
         end
         S_WAIT_W: begin
            if (dma_resp_valid) begin
               load_w  = 1'b1;
               state_d = S_REQ_X;
            end
         end
         S_REQ_X: begin
            dma_re   = 1'b1;
            dma_addr = x_ptr_q;
            if (dma_req_ready) state_d = S_WAIT_X;
         end
         S_WAIT_X: begin
            if (dma_resp_valid) begin
               load_x  = 1'b1;
               state_d = S_FEED;
            end
         end
         S_FEED: begin
            en          = 1'b1;
            feed_active = 1'b1;
            if (feed_last) state_d = more_chunks ? S_REQ_W : S_DRAIN;
         end
         S_DRAIN: begin
            en = 1'b1;
            if (drain_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Config latch, chunk pointers, drain counter and sticky done flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr_q     <= '0;
         x_ptr_q     <= '0;
         x_stride_q  <= '0;
         k_rem_q     <= '0;
         drain_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  w_ptr_q    <= w_addr;
                  x_ptr_q    <= x_addr;
                  x_stride_q <= x_stride;
                  k_rem_q    <= k_dim;
                  done_q     <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (k_rem_q == '0) done_q <= 1'b1;
            end
            S_FEED: begin
               if (feed_last && more_chunks) begin
                  w_ptr_q <= w_ptr_q + 32'(BEAT_BYTES);
                  x_ptr_q <= x_ptr_q + x_stride_q;
                  k_rem_q <= k_rem_q - 32'(N);
               end
            end
            S_DRAIN: begin
               if (drain_last) begin
                  drain_cnt_q <= '0;
                  done_q      <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DCW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   systolic_skew_feeder #(
      .N      (N),
      .DATA_W (DATA_W),
      .BEAT_W (BEAT_W)
   ) u_feeder (
      .clk         (clk),
      .reset       (reset),
      .load_w      (load_w),
      .load_x      (load_x),
      .beat        (dma_rdata),
      .k_valid     (k_valid),
      .feed_active (feed_active),
      .feed_last   (feed_last),
      .a_left      (a_left),
      .b_top       (b_top)
   );

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: DMA responder, feed-frame scoreboard and an
// output-stationary array model that accumulates what the DUT actually feeds.
`timescale 1ns/1ps
module tb_systolic_feed_ctrl;
   import systolic_pkg::*;

   localparam int FW = 2 * N * DATA_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                     start;
   logic [31:0]              w_addr, x_addr, k_dim, x_stride;
   logic [31:0]              dma_addr;
   logic                     dma_re, dma_req_ready, dma_resp_valid;
   logic [BEAT_W-1:0]        dma_rdata;
   logic                     clear_acc, en, busy, done;
   logic signed [DATA_W-1:0] a_left [N];
   logic signed [DATA_W-1:0] b_top  [N];
   state_t                   dbg_state;

   systolic_feed_ctrl #(.N(N), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .w_addr(w_addr), .x_addr(x_addr), .k_dim(k_dim), .x_stride(x_stride),
      .dma_addr(dma_addr), .dma_re(dma_re), .dma_req_ready(dma_req_ready),
      .dma_resp_valid(dma_resp_valid), .dma_rdata(dma_rdata),
      .clear_acc(clear_acc), .en(en), .a_left(a_left), .b_top(b_top),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- DMA responder ----------------
   logic [BEAT_W-1:0] mem [int unsigned];
   int          resp_lat   = 0;
   int          stall_next = 0;
   bit          eager      = 1'b0;
   bit          pend       = 1'b0;
   int          pend_wait  = 0;
   logic [31:0] pend_addr  = '0;
   logic [31:0] got_addr[$];

   function automatic logic [BEAT_W-1:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : '0;
   endfunction

   initial begin
      dma_req_ready  = 1'b0;
      dma_resp_valid = 1'b0;
      dma_rdata      = '0;
      forever begin
         @(negedge clk);
         dma_req_ready  = 1'b0;
         dma_resp_valid = 1'b0;
         dma_rdata      = '0;
         if (pend) begin
            if (pend_wait == 0) begin
               dma_resp_valid = 1'b1;
               dma_rdata      = mem_rd(pend_addr);
               pend           = 1'b0;
            end else begin
               pend_wait--;
            end
         end else if (dma_re === 1'b1) begin
            if (stall_next > 0) begin
               stall_next--;
            end else begin
               dma_req_ready = 1'b1;
               got_addr.push_back(dma_addr);
               pend      = 1'b1;
               pend_addr = dma_addr;
               pend_wait = resp_lat;
               if (eager) begin
                  dma_resp_valid = 1'b1;
                  dma_rdata      = {8{32'hdead_beef}};
               end
            end
         end
      end
   end

   // ---------------- scoreboard + array model ----------------
   logic [FW-1:0] exp_q[$];
   int            exp_runs[$];
   int            got_runs[$];
   int            re_runs[$];
   logic [31:0]   exp_addr[$];
   longint        exp_c [N][N];
   longint        acc   [N][N];
   logic signed [DATA_W-1:0] ar [N][N];
   logic signed [DATA_W-1:0] br [N][N];
   bit            mon_on = 1'b0;
   int            en_run = 0, re_run = 0, clr_cnt = 0, en_cycles = 0;
   bit            prev_re = 1'b0;
   logic [31:0]   prev_addr = '0;

   initial begin
      logic [FW-1:0]            frame, e;
      logic signed [DATA_W-1:0] ain, bin;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc[i][j] = 0; ar[i][j] = '0; br[i][j] = '0;
         end
      forever begin
         @(negedge clk);
         if (mon_on) begin
            for (int i = 0; i < N; i++) begin
               frame[i*DATA_W +: DATA_W]     = a_left[i];
               frame[(N+i)*DATA_W +: DATA_W] = b_top[i];
            end
            if (en) begin
               en_cycles++;
               en_run++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL feed_extra actual=%0h expected=no_more_enable_cycles", frame);
               end else begin
                  e = exp_q.pop_front();
                  chk("feed_frame", frame, e);
               end
            end else begin
               if (en_run > 0) begin
                  got_runs.push_back(en_run);
                  en_run = 0;
               end
               chk("feed_idle_zero", frame, '0);
            end
            if (dma_re) begin
               chk("re_during_en", en, 1'b0);
               if (prev_re) chk("req_addr_stable", dma_addr, prev_addr);
               re_run++;
            end else if (re_run > 0) begin
               re_runs.push_back(re_run);
               re_run = 0;
            end
            prev_re   = dma_re;
            prev_addr = dma_addr;
            // Output-stationary array: a moves right, b moves down, each PE accumulates.
            if (clear_acc) begin
               clr_cnt++;
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++) begin
                     acc[i][j] = 0; ar[i][j] = '0; br[i][j] = '0;
                  end
            end else if (en) begin
               for (int i = N - 1; i >= 0; i--)
                  for (int j = N - 1; j >= 0; j--) begin
                     if (j == 0) ain = a_left[i]; else ain = ar[i][j-1];
                     if (i == 0) bin = b_top[j];  else bin = br[i-1][j];
                     acc[i][j] += longint'(ain) * longint'(bin);
                     ar[i][j] = ain;
                     br[i][j] = bin;
                  end
            end
         end
      end
   end

   // Expected address list, feed frames, enable runs and product from the rules.
   task automatic build_model(input logic [31:0] wb, input logic [31:0] xb,
                              input logic [31:0] kd, input logic [31:0] st);
      int            chunks;
      int            wm [N][N];
      int            xm [N][N];
      logic [BEAT_W-1:0] wbeat, xbeat;
      logic [31:0]   wa, xa;
      logic [FW-1:0] fr;
      exp_q.delete(); exp_runs.delete(); exp_addr.delete();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) exp_c[i][j] = 0;
      chunks = int'((kd + 32'(N - 1)) / 32'(N));
      for (int c = 0; c < chunks; c++) begin
         wa = wb + 32'(32 * c);
         xa = xb + st * 32'(c);
         exp_addr.push_back(wa);
         exp_addr.push_back(xa);
         wbeat = mem_rd(wa);
         xbeat = mem_rd(xa);
         for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
               if (32'(c * N + k) < kd) begin
                  wm[r][k] = int'($signed(wbeat[(r*N+k)*DATA_W +: DATA_W]));
                  xm[k][r] = int'($signed(xbeat[(k*N+r)*DATA_W +: DATA_W]));
               end else begin
                  wm[r][k] = 0;
                  xm[k][r] = 0;
               end
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               for (int k = 0; k < N; k++)
                  exp_c[i][j] += longint'(wm[i][k]) * longint'(xm[k][j]);
         for (int t = 0; t < FEED_LEN; t++) begin
            fr = '0;
            for (int i = 0; i < N; i++) begin
               if (t - i >= 0 && t - i < N) begin
                  fr[i*DATA_W +: DATA_W]     = DATA_W'(wm[i][t-i]);
                  fr[(N+i)*DATA_W +: DATA_W] = DATA_W'(xm[t-i][i]);
               end
            end
            exp_q.push_back(fr);
         end
         if (c == chunks - 1) begin
            for (int d = 0; d < DRAIN_LEN; d++) exp_q.push_back('0);
            exp_runs.push_back(FEED_LEN + DRAIN_LEN);
         end else begin
            exp_runs.push_back(FEED_LEN);
         end
      end
   endtask

   function automatic logic [BEAT_W-1:0] make_beat(input int m [N][N]);
      logic [BEAT_W-1:0] b;
      b = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) b[(r*N+c)*DATA_W +: DATA_W] = DATA_W'(m[r][c]);
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic [31:0] wb, input logic [31:0] xb,
                              input logic [31:0] kd, input logic [31:0] st);
      @(negedge clk);
      w_addr = wb; x_addr = xb; k_dim = kd; x_stride = st;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic launch(input logic [31:0] wb, input logic [31:0] xb,
                         input logic [31:0] kd, input logic [31:0] st);
      got_addr.delete(); got_runs.delete(); re_runs.delete();
      clr_cnt = 0;
      pulse_start(wb, xb, kd, st);
   endtask

   task automatic wait_state(input string name, input state_t s);
      int cyc;
      cyc = 0;
      while (dbg_state !== s && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk(name, dbg_state, s);
   endtask

   task automatic finish_op(input string name);
      int cyc;
      cyc = 0;
      while (!(done === 1'b1 && busy === 1'b0) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_done_timeout"}, cyc < 2000, 1'b1);
      repeat (3) @(negedge clk);
      chk({name, "_done"}, done, 1'b1);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_clear_pulses"}, clr_cnt, 1);
      chk({name, "_addr_count"}, got_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
         chk({name, "_addr"}, got_addr[i], exp_addr[i]);
      chk({name, "_run_count"}, got_runs.size(), exp_runs.size());
      for (int i = 0; i < exp_runs.size() && i < got_runs.size(); i++)
         chk({name, "_en_run_len"}, got_runs[i], exp_runs[i]);
      chk({name, "_frames_left"}, exp_q.size(), 0);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) chk({name, "_acc"}, acc[i][j], exp_c[i][j]);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int wm [N][N];
      int xm [N][N];
      int snap;
      reset = 1'b1; start = 1'b0;
      w_addr = '0; x_addr = '0; k_dim = '0; x_stride = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_dma_re", dma_re, 1'b0);
      chk("rst_dma_addr", dma_addr, 32'h0);
      chk("rst_clear_acc", clear_acc, 1'b0);
      chk("rst_en", en, 1'b0);
      chk("rst_a_left0", a_left[0], '0);
      chk("rst_state", dbg_state, S_IDLE);
      mon_on = 1'b1;

      // Identity W times counting X, single chunk, zero-latency DMA.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            wm[r][c] = (r == c) ? 1 : 0;
            xm[r][c] = r * 4 + c + 1;
         end
      mem[32'h1000] = make_beat(wm);
      mem[32'h2000] = make_beat(xm);
      build_model(32'h1000, 32'h2000, 32'd4, 32'h20);
      launch(32'h1000, 32'h2000, 32'd4, 32'h20);
      finish_op("t1");
      chk("t1_addr0", got_addr[0], 32'h1000);
      chk("t1_addr1", got_addr[1], 32'h2000);
      chk("t1_c00", acc[0][0], 1);
      chk("t1_c12", acc[1][2], 7);
      chk("t1_c20", acc[2][0], 9);
      chk("t1_c33", acc[3][3], 16);

      // Two chunks, k=6 tail, stride 0x40; a start pulse during FEED must be ignored.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            wm[r][c] = 2;
            xm[r][c] = 3;
         end
      mem[32'h3000] = make_beat(wm);
      mem[32'h3020] = make_beat(wm);
      mem[32'h4000] = make_beat(xm);
      mem[32'h4040] = make_beat(xm);
      build_model(32'h3000, 32'h4000, 32'd6, 32'h40);
      launch(32'h3000, 32'h4000, 32'd6, 32'h40);
      wait_state("t2_reach_feed", S_FEED);
      pulse_start(32'h9000, 32'h9100, 32'd4, 32'h8);
      finish_op("t2");
      chk("t2_addr2", got_addr[2], 32'h3020);
      chk("t2_addr3", got_addr[3], 32'h4040);
      chk("t2_c00", acc[0][0], 36);
      chk("t2_c31", acc[3][1], 36);

      // Request stalled five cycles, response three cycles late.
      stall_next = 5;
      resp_lat   = 3;
      build_model(32'h1000, 32'h2000, 32'd4, 32'h0);
      launch(32'h1000, 32'h2000, 32'd4, 32'h0);
      finish_op("t3");
      chk("t3_re_held", re_runs[0], 6);
      chk("t3_re_second", re_runs[1], 1);
      chk("t3_c12", acc[1][2], 7);

      // Garbage beat offered in the accept cycle must not be captured.
      resp_lat = 0;
      eager    = 1'b1;
      build_model(32'h1000, 32'h2000, 32'd4, 32'h0);
      launch(32'h1000, 32'h2000, 32'd4, 32'h0);
      finish_op("t4");
      eager = 1'b0;
      chk("t4_c33", acc[3][3], 16);

      // k_dim = 0: one clear cycle, no DMA, done two cycles after start.
      build_model(32'h1000, 32'h2000, 32'd0, 32'h0);
      launch(32'h1000, 32'h2000, 32'd0, 32'h0);
      chk("t5_clear", clear_acc, 1'b1);
      chk("t5_busy_clear", busy, 1'b1);
      chk("t5_done_early", done, 1'b0);
      @(negedge clk);
      chk("t5_done", done, 1'b1);
      chk("t5_busy", busy, 1'b0);
      chk("t5_clear_off", clear_acc, 1'b0);
      repeat (3) @(negedge clk);
      chk("t5_no_dma", got_addr.size(), 0);
      chk("t5_no_en", got_runs.size(), 0);
      chk("t5_clear_pulses", clr_cnt, 1);

      // Reset while waiting on the X beat; the late beat must be ignored.
      resp_lat = 10;
      launch(32'h1000, 32'h2000, 32'd4, 32'h0);
      wait_state("t6_reach_wait_x", S_WAIT_X);
      snap  = en_cycles;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t6_state", dbg_state, S_IDLE);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_dma_re", dma_re, 1'b0);
      chk("t6_dma_addr", dma_addr, 32'h0);
      chk("t6_en", en, 1'b0);
      chk("t6_clear", clear_acc, 1'b0);
      repeat (20) @(negedge clk);
      chk("t6_stray_pending", pend, 1'b0);
      chk("t6_state_after", dbg_state, S_IDLE);
      chk("t6_busy_after", busy, 1'b0);
      chk("t6_done_after", done, 1'b0);
      chk("t6_no_feed", en_cycles, snap);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
